fsm_step_monitor: RTL and testbench

- Downstream observer for the 9-state step FSM. It consumes the FSM's 4-bit state output `y` and the same `en` qualifier.
- Measures dwell time in each state, counts completed laps (8 -> 0 wraps) and flags timeouts and illegal state or step behaviour.
- All outputs are registered; the block feeds status/debug logic and does not back-pressure the FSM.

---
 rtl/fsm_pkg.sv | 25 ++
 rtl/fsm_step_check.sv | 31 +++
 rtl/fsm_step_monitor.sv | 144 ++++++++++++++
 tb/tb_fsm_step_monitor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the 9-state step FSM and its observers.
// Step order lives here so every consumer agrees on the successor of each state.
package fsm_pkg;

  localparam int NUM_STATES = 9;
  localparam int SW         = 4;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_TMO   = 2'd1,
    ST_FAULT = 2'd2
  } status_e;

  // Successor of a state; the last legal state wraps to 0.
  function automatic logic [SW-1:0] next_state(input logic [SW-1:0] prev);
    logic [SW-1:0] nxt;
    if (prev == SW'(NUM_STATES - 1)) begin
      nxt = {SW{1'b0}};
    end else begin
      nxt = prev + SW'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fsm_step_check.sv
// Combinational decode of one sampled step (prev -> st): illegal value,
// legal step and lap wrap.
module fsm_step_check
  import fsm_pkg::*;
(
  input  logic [SW-1:0] prev,
  input  logic [SW-1:0] st,
  output logic          illegal_val,
  output logic          legal_step,
  output logic          wrap
);

  // Classify the step; an out-of-range prev only permits an (illegal) hold.
  always_comb begin
    illegal_val = 1'b0;
    legal_step  = 1'b0;
    wrap        = 1'b0;
    illegal_val = ({1'b0, st} >= (SW + 1)'(NUM_STATES));
    if (illegal_val) begin
      legal_step = 1'b0;
    end else if (st == prev) begin
      legal_step = 1'b1;
    end else if ({1'b0, prev} < (SW + 1)'(NUM_STATES)) begin
      legal_step = (st == next_state(prev));
    end else begin
      legal_step = 1'b0;
    end
    wrap = (prev == SW'(NUM_STATES - 1)) && (st == {SW{1'b0}});
  end

endmodule

// File: rtl/fsm_step_monitor.sv
// Observer for the step FSM: dwell time, lap count, sticky timeout/error
// flags and a registered status summary.
module fsm_step_monitor
  import fsm_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 200,
  parameter int LW      = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [SW-1:0] st,
  input  logic          clr,
  output logic          chg,
  output logic [DW-1:0] dwell,
  output logic [LW-1:0] laps,
  output logic          tmo,
  output logic          err,
  output logic [1:0]    status
);

  logic [SW-1:0] prev_r, prev_s;
  logic          chg_r, chg_s;
  logic [DW-1:0] dwell_r, dwell_s;
  logic [LW-1:0] laps_r, laps_s;
  logic          tmo_r, tmo_s, tmo_set_s;
  logic          err_r, err_s, err_set_s;
  status_e       status_r, status_s;
  logic          changed_s;
  logic          illegal_val_s, legal_step_s, wrap_s;

  fsm_step_check u_check (
    .prev        (prev_r),
    .st          (st),
    .illegal_val (illegal_val_s),
    .legal_step  (legal_step_s),
    .wrap        (wrap_s)
  );

  // Counters and sticky flags; clr clears flags/laps but a same-cycle set wins.
  always_comb begin
    prev_s    = prev_r;
    chg_s     = 1'b0;
    dwell_s   = dwell_r;
    laps_s    = laps_r;
    tmo_set_s = 1'b0;
    err_set_s = 1'b0;
    changed_s = (st != prev_r);
    if (en) begin
      prev_s    = st;
      chg_s     = changed_s;
      tmo_set_s = !changed_s &&
                  ((({1'b0, dwell_r} + (DW + 1)'(1)) == (DW + 1)'(TIMEOUT)) ||
                   (dwell_r >= DW'(TIMEOUT)));
      err_set_s = illegal_val_s || !legal_step_s;
      if (changed_s) begin
        dwell_s = {DW{1'b0}};
      end else if (dwell_r == {DW{1'b1}}) begin
        dwell_s = dwell_r;
      end else begin
        dwell_s = dwell_r + DW'(1);
      end
      if (wrap_s && legal_step_s) begin
        laps_s = laps_r + LW'(1);
      end else begin
        laps_s = laps_r;
      end
    end else begin
      prev_s = prev_r;
    end
    if (clr) begin
      laps_s = {LW{1'b0}};
    end else begin
      laps_s = laps_s;
    end
    tmo_s = tmo_set_s || (tmo_r && !clr);
    err_s = err_set_s || (err_r && !clr);
  end

  // Status FSM: FAULT > TIMEOUT > OK, left only through clr.
  always_comb begin
    status_s = status_r;
    case (status_r)
      ST_OK: begin
        if (err_set_s) begin
          status_s = ST_FAULT;
        end else if (tmo_set_s) begin
          status_s = ST_TMO;
        end else begin
          status_s = ST_OK;
        end
      end
      ST_TMO: begin
        if (err_set_s) begin
          status_s = ST_FAULT;
        end else if (clr && !tmo_set_s) begin
          status_s = ST_OK;
        end else begin
          status_s = ST_TMO;
        end
      end
      ST_FAULT: begin
        if (clr && !err_set_s) begin
          status_s = tmo_set_s ? ST_TMO : ST_OK;
        end else begin
          status_s = ST_FAULT;
        end
      end
      default: begin
        status_s = ST_OK;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_r   <= {SW{1'b0}};
      chg_r    <= 1'b0;
      dwell_r  <= {DW{1'b0}};
      laps_r   <= {LW{1'b0}};
      tmo_r    <= 1'b0;
      err_r    <= 1'b0;
      status_r <= ST_OK;
    end else begin
      prev_r   <= prev_s;
      chg_r    <= chg_s;
      dwell_r  <= dwell_s;
      laps_r   <= laps_s;
      tmo_r    <= tmo_s;
      err_r    <= err_s;
      status_r <= status_s;
    end
  end

  assign chg    = chg_r;
  assign dwell  = dwell_r;
  assign laps   = laps_r;
  assign tmo    = tmo_r;
  assign err    = err_r;
  assign status = status_r;

endmodule

// File: tb/tb_fsm_step_monitor.sv
// Scoreboard bench for fsm_step_monitor: directed scenarios plus random
// steps, checked against a flag/counter model of the observer's rules.
module tb_fsm_step_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic [3:0] st    = 4'd0;
  logic       clr   = 1'b0;
  logic       chg;
  logic [7:0] dwell;
  logic [7:0] laps;
  logic       tmo;
  logic       err;
  logic [1:0] status;

  fsm_step_monitor dut (
    .clock  (clock),
    .reset  (reset),
    .en     (en),
    .st     (st),
    .clr    (clr),
    .chg    (chg),
    .dwell  (dwell),
    .laps   (laps),
    .tmo    (tmo),
    .err    (err),
    .status (status)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int chg;
    int dwell;
    int laps;
    int tmo;
    int err;
    int status;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model state
  int m_prev = 0, m_dwell = 0, m_laps = 0, m_tmo = 0, m_err = 0, m_chg = 0;
  int last_st = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  // monitor: compare the DUT against every expectation due this cycle
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) begin
        cmp("stale_entry", e.due, cyc);
      end else begin
        cmp("chg", int'(chg), e.chg);
        cmp("dwell", int'(dwell), e.dwell);
        cmp("laps", int'(laps), e.laps);
        cmp("tmo", int'(tmo), e.tmo);
        cmp("err", int'(err), e.err);
        cmp("status", int'(status), e.status);
      end
    end
  end

  function automatic int is_legal(input int p, input int s);
    if (s >= 9) return 0;
    if (s == p) return 1;
    if (p < 8 && s == p + 1) return 1;
    if (p == 8 && s == 0) return 1;
    return 0;
  endfunction

  task automatic step(input int e, input int s, input int c, input int r);
    exp_t x;
    int changed, tset, eset, legal;
    @(posedge clock);
    #1;
    en = e[0]; st = s[3:0]; clr = c[0]; reset = r[0];
    last_st = s;
    if (r != 0) begin
      m_prev = 0; m_dwell = 0; m_laps = 0; m_tmo = 0; m_err = 0; m_chg = 0;
    end else begin
      m_chg = 0;
      tset = 0;
      eset = 0;
      if (e != 0) begin
        changed = (s != m_prev);
        legal   = is_legal(m_prev, s);
        m_chg   = changed;
        tset    = !changed && (m_dwell + 1 == 200 || m_dwell >= 200);
        eset    = !legal;
        if (m_prev == 8 && s == 0 && legal) m_laps = (m_laps + 1) % 256;
        m_dwell = changed ? 0 : ((m_dwell + 1 > 255) ? 255 : m_dwell + 1);
        m_prev  = s;
      end
      if (c != 0) begin
        m_tmo = 0; m_err = 0; m_laps = 0;
      end
      if (tset) m_tmo = 1;
      if (eset) m_err = 1;
    end
    x.due = cyc + 1;
    x.chg = m_chg; x.dwell = m_dwell; x.laps = m_laps;
    x.tmo = m_tmo; x.err = m_err;
    x.status = m_err ? 2 : (m_tmo ? 1 : 0);
    q.push_back(x);
  endtask

  initial begin
    int r, s;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    // hold at 0
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    // one full lap
    for (int i = 1; i <= 9; i++) step(1, i % 9, 0, 0);
    // hold 3 past the timeout, then clear
    for (int i = 1; i <= 3; i++) step(1, i, 0, 0);
    for (int i = 0; i < 202; i++) step(1, 3, 0, 0);
    step(1, 3, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 3, 0, 0);
    // illegal jump 2 -> 5, then clr with an illegal value
    step(0, 0, 0, 1);
    for (int i = 0; i <= 2; i++) step(1, i, 0, 0);
    step(1, 5, 0, 0);
    step(1, 12, 1, 0);
    step(1, 13, 0, 0);
    step(1, 13, 1, 0);
    step(1, 0, 0, 1);
    // enable low while st is constant
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 2, 0, 0);
    step(1, 2, 0, 0);
    // 256 laps wrap the lap counter, then reset mid-lap
    step(0, 0, 0, 1);
    for (int l = 0; l < 256; l++)
      for (int i = 1; i <= 9; i++) step(1, i % 9, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, i, 0, 0);
    step(1, 4, 0, 1);
    step(0, 0, 0, 0);
    // random stepping with occasional faults, clears and resets
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4)      s = last_st;
      else if (r <= 8) s = (last_st >= 8) ? 0 : last_st + 1;
      else             s = int'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0) ? 1 : 0, s,
           ($urandom_range(0, 49) == 0) ? 1 : 0,
           ($urandom_range(0, 299) == 0) ? 1 : 0);
    end
    step(0, last_st, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    #1;
    cmp("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
